// File: rtl/int_alu_if.sv
`timescale 1ns/1ps
// Issue / writeback bundle of the integer execute unit.
// master: issue stage side (drives operands, observes results).
// slave:  the execute unit itself.
interface int_alu_if #(
  parameter int XLEN                 = 64,
  parameter int PC_WIDTH             = 32,
  parameter int VIRTUAL_ADDR_LEN     = 32,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int CSR_ADDR_LEN         = 12,
  parameter int EXCEPTION_CODE_WIDTH = 4
);
  logic                            stall;
  logic                            flush;
  logic                            valid_i;
  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_i;
  logic [ROB_INDEX_WIDTH-1:0]      rob_index_i;
  logic [XLEN-1:0]                 input_a;
  logic [XLEN-1:0]                 input_b;
  logic                            half;
  logic [2:0]                      function_select;
  logic                            function_modifier;
  logic                            jump_i;
  logic                            branch_i;
  logic [PC_WIDTH-1:0]             pc_i;
  logic [PC_WIDTH-1:0]             next_pc_i;
  logic                            is_csr_i;
  logic [CSR_ADDR_LEN-1:0]         csr_address_i;
  logic [XLEN-1:0]                 csr_data_i;
  logic                            csr_read_i;
  logic                            csr_write_i;
  logic                            csr_readable_i;
  logic                            csr_writeable_i;

  logic [XLEN-1:0]                 result;
  logic                            ready_o;
  logic                            done_o;
  logic [ROB_INDEX_WIDTH-1:0]      rob_index_o;
  logic [PHY_REG_ADDR_WIDTH-1:0]   rd_addr_o;
  logic                            jump_o;
  logic                            branch_o;
  logic [VIRTUAL_ADDR_LEN-1:0]     pc_o;
  logic [VIRTUAL_ADDR_LEN-1:0]     next_pc_o;
  logic                            csr_valid_o;
  logic                            csr_read_o;
  logic                            csr_write_o;
  logic [XLEN-1:0]                 csr_data_o;
  logic [CSR_ADDR_LEN-1:0]         csr_address_o;
  logic                            exception_valid_o;
  logic [EXCEPTION_CODE_WIDTH-1:0] ecause_o;

  modport master (
    output stall, flush, valid_i, rd_addr_i, rob_index_i, input_a, input_b,
           half, function_select, function_modifier, jump_i, branch_i,
           pc_i, next_pc_i, is_csr_i, csr_address_i, csr_data_i,
           csr_read_i, csr_write_i, csr_readable_i, csr_writeable_i,
    input  result, ready_o, done_o, rob_index_o, rd_addr_o, jump_o,
           branch_o, pc_o, next_pc_o, csr_valid_o, csr_read_o, csr_write_o,
           csr_data_o, csr_address_o, exception_valid_o, ecause_o
  );

  modport slave (
    input  stall, flush, valid_i, rd_addr_i, rob_index_i, input_a, input_b,
           half, function_select, function_modifier, jump_i, branch_i,
           pc_i, next_pc_i, is_csr_i, csr_address_i, csr_data_i,
           csr_read_i, csr_write_i, csr_readable_i, csr_writeable_i,
    output result, ready_o, done_o, rob_index_o, rd_addr_o, jump_o,
           branch_o, pc_o, next_pc_o, csr_valid_o, csr_read_o, csr_write_o,
           csr_data_o, csr_address_o, exception_valid_o, ecause_o
  );
endinterface

// File: rtl/int_alu.sv
`timescale 1ns/1ps
// Single-cycle integer execute unit: RV64I/W ALU ops, branch/jump targets,
// CSR write values and CSR access legality. Results appear one cycle after
// issue, tagged with the ROB index and physical destination.
module int_alu #(
  parameter int XLEN                 = 64,
  parameter int PC_WIDTH             = 32,
  parameter int VIRTUAL_ADDR_LEN     = 32,
  parameter int ROB_INDEX_WIDTH      = 4,
  parameter int PHY_REG_ADDR_WIDTH   = 6,
  parameter int CSR_ADDR_LEN         = 12,
  parameter int EXCEPTION_CODE_WIDTH = 4
) (
  input logic    clk,
  input logic    rstn,   // active-high synchronous clear despite the name
  int_alu_if.slave io
);
  localparam logic [EXCEPTION_CODE_WIDTH-1:0] ECAUSE_ILLEGAL =
    EXCEPTION_CODE_WIDTH'(2);

  logic                            w_accept;
  logic [XLEN-1:0]                 w_sum;
  logic [XLEN-1:0]                 w_sra;
  logic [XLEN-1:0]                 w_full;
  logic [31:0]                     w_a32;
  logic [31:0]                     w_b32;
  logic [31:0]                     w_sraw;
  logic [31:0]                     w_word;
  logic                            w_word_op;
  logic [XLEN-1:0]                 w_alu;
  logic [XLEN-1:0]                 w_csr_val;
  logic [XLEN-1:0]                 w_result;
  logic                            w_illegal;
  logic [PC_WIDTH-1:0]             w_pc;
  logic [PC_WIDTH-1:0]             w_next_pc;

  logic [XLEN-1:0]                 r_result;
  logic                            r_done;
  logic [ROB_INDEX_WIDTH-1:0]      r_rob_index;
  logic [PHY_REG_ADDR_WIDTH-1:0]   r_rd_addr;
  logic                            r_jump;
  logic                            r_branch;
  logic [VIRTUAL_ADDR_LEN-1:0]     r_pc;
  logic [VIRTUAL_ADDR_LEN-1:0]     r_next_pc;
  logic                            r_csr_valid;
  logic                            r_csr_read;
  logic                            r_csr_write;
  logic [XLEN-1:0]                 r_csr_data;
  logic [CSR_ADDR_LEN-1:0]         r_csr_address;
  logic                            r_exception;
  logic [EXCEPTION_CODE_WIDTH-1:0] r_ecause;

  assign io.ready_o = ~io.stall;
  assign w_accept   = io.valid_i & ~io.stall;

  assign w_sum     = io.input_a + io.input_b;
  assign w_sra     = $signed(io.input_a) >>> io.input_b[5:0];
  assign w_a32     = io.input_a[31:0];
  assign w_b32     = io.input_b[31:0];
  assign w_sraw    = $signed(w_a32) >>> w_b32[4:0];
  assign w_pc      = io.pc_i;
  assign w_next_pc = io.next_pc_i;

  // Only ADD/SUB/SLL/SRL/SRA have W forms; other funct3 stay full width.
  assign w_word_op = io.half & ((io.function_select == 3'b000) |
                                (io.function_select == 3'b001) |
                                (io.function_select == 3'b101));

  assign w_illegal = io.is_csr_i &
                     ((io.csr_read_i  & ~io.csr_readable_i) |
                      (io.csr_write_i & ~io.csr_writeable_i));

  // Full-width RV64I result selected by funct3 / modifier.
  always_comb begin
    w_full = '0;
    case (io.function_select)
      3'b000: w_full = io.function_modifier ? (io.input_a - io.input_b) : w_sum;
      3'b001: w_full = io.input_a << io.input_b[5:0];
      3'b010: w_full = {{(XLEN-1){1'b0}},
                        ($signed(io.input_a) < $signed(io.input_b))};
      3'b011: w_full = {{(XLEN-1){1'b0}}, (io.input_a < io.input_b)};
      3'b100: w_full = io.input_a ^ io.input_b;
      3'b101: w_full = io.function_modifier ? w_sra
                                            : (io.input_a >> io.input_b[5:0]);
      3'b110: w_full = io.input_a | io.input_b;
      default: w_full = io.input_a & io.input_b;
    endcase
  end

  // 32-bit W-form result, sign-extended afterwards.
  always_comb begin
    w_word = '0;
    case (io.function_select)
      3'b000: w_word = io.function_modifier ? (w_a32 - w_b32) : (w_a32 + w_b32);
      3'b001: w_word = w_a32 << w_b32[4:0];
      3'b101: w_word = io.function_modifier ? w_sraw : (w_a32 >> w_b32[4:0]);
      default: w_word = w_full[31:0];
    endcase
  end

  assign w_alu = w_word_op ? {{(XLEN-32){w_word[31]}}, w_word} : w_full;

  // New CSR value: a is the old CSR contents, b is rs1 or zimm.
  always_comb begin
    w_csr_val = '0;
    case (io.function_select[1:0])
      2'b01:   w_csr_val = io.input_b;
      2'b10:   w_csr_val = io.input_a | io.input_b;
      2'b11:   w_csr_val = io.input_a & ~io.input_b;
      default: w_csr_val = io.input_a;
    endcase
  end

  // CSR decode wins, then control-flow target (bit 0 cleared), then ALU.
  always_comb begin
    w_result = w_alu;
    if (io.is_csr_i)
      w_result = w_csr_val;
    else if (io.branch_i)
      w_result = {w_sum[XLEN-1:1], 1'b0};
  end

  // Output registers: clear on reset/flush, hold on stall, load on accept.
  always_ff @(posedge clk) begin
    if (rstn || io.flush) begin
      r_result      <= '0;
      r_done        <= 1'b0;
      r_rob_index   <= '0;
      r_rd_addr     <= '0;
      r_jump        <= 1'b0;
      r_branch      <= 1'b0;
      r_pc          <= '0;
      r_next_pc     <= '0;
      r_csr_valid   <= 1'b0;
      r_csr_read    <= 1'b0;
      r_csr_write   <= 1'b0;
      r_csr_data    <= '0;
      r_csr_address <= '0;
      r_exception   <= 1'b0;
      r_ecause      <= '0;
    end else if (w_accept) begin
      r_result      <= w_result;
      r_done        <= 1'b1;
      r_rob_index   <= io.rob_index_i;
      r_rd_addr     <= io.rd_addr_i;
      r_jump        <= io.jump_i;
      r_branch      <= io.branch_i;
      r_pc          <= VIRTUAL_ADDR_LEN'(w_pc);
      r_next_pc     <= VIRTUAL_ADDR_LEN'(w_next_pc);
      r_csr_valid   <= io.is_csr_i & ~w_illegal;
      r_csr_read    <= io.csr_read_i & ~w_illegal;
      r_csr_write   <= io.csr_write_i & ~w_illegal;
      r_csr_data    <= io.csr_data_i;
      r_csr_address <= io.csr_address_i;
      r_exception   <= w_illegal;
      r_ecause      <= w_illegal ? ECAUSE_ILLEGAL : '0;
    end else if (!io.stall) begin
      r_done        <= 1'b0;
    end
  end

  assign io.result            = r_result;
  assign io.done_o            = r_done;
  assign io.rob_index_o       = r_rob_index;
  assign io.rd_addr_o         = r_rd_addr;
  assign io.jump_o            = r_jump;
  assign io.branch_o          = r_branch;
  assign io.pc_o              = r_pc;
  assign io.next_pc_o         = r_next_pc;
  assign io.csr_valid_o       = r_csr_valid;
  assign io.csr_read_o        = r_csr_read;
  assign io.csr_write_o       = r_csr_write;
  assign io.csr_data_o        = r_csr_data;
  assign io.csr_address_o     = r_csr_address;
  assign io.exception_valid_o = r_exception;
  assign io.ecause_o          = r_ecause;
endmodule

// File: tb/tb_int_alu.sv
`timescale 1ns/1ps
// Bench for int_alu: directed literal cases plus randomized traffic checked
// every cycle against a behavioural model of the unit.
module tb_int_alu;
  logic clk;
  logic rstn;
  int   n_cmp;
  int   n_err;
  bit   cmp_en;

  int_alu_if bus ();
  int_alu dut (.clk(clk), .rstn(rstn), .io(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a, b;
    logic        half, mod, jump, branch, is_csr;
    logic [2:0]  fs;
    logic [31:0] pc, npc;
    logic [11:0] caddr;
    logic [63:0] cdata;
    logic        cr, cw, crd, cwr;
    logic [3:0]  rob;
    logic [5:0]  rd;
  } op_t;

  typedef struct {
    logic [63:0] result;
    logic        done, jump, branch, csr_valid, csr_read, csr_write, exc;
    logic [3:0]  rob, ecause;
    logic [5:0]  rd;
    logic [31:0] pc, npc;
    logic [63:0] csr_data;
    logic [11:0] csr_addr;
  } out_t;

  out_t exp_o;
  bit   exp_clr;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  function automatic out_t zero_out();
    out_t z;
    z.result = '0; z.done = 0; z.jump = 0; z.branch = 0; z.csr_valid = 0;
    z.csr_read = 0; z.csr_write = 0; z.exc = 0; z.rob = '0; z.ecause = '0;
    z.rd = '0; z.pc = '0; z.npc = '0; z.csr_data = '0; z.csr_addr = '0;
    return z;
  endfunction

  // Architectural result of one instruction.
  function automatic logic [63:0] ref_result(op_t o);
    int unsigned sh;
    logic [31:0] ua, ub;
    int          sa, w;
    longint      la;
    logic [63:0] r;
    if (o.is_csr) begin
      case (o.fs[1:0])
        2'd1: return o.b;
        2'd2: return o.a | o.b;
        2'd3: return o.a & ~o.b;
        default: return o.a;
      endcase
    end
    if (o.branch) return (o.a + o.b) & ~64'd1;
    ua = o.a[31:0];
    ub = o.b[31:0];
    if (o.half && (o.fs == 3'd0 || o.fs == 3'd1 || o.fs == 3'd5)) begin
      sh = int'(ub[4:0]);
      sa = ua;
      if (o.fs == 3'd0) w = o.mod ? sa - int'(ub) : sa + int'(ub);
      else if (o.fs == 3'd1) w = int'(ua << sh);
      else if (o.mod) w = sa >>> sh;
      else w = int'(ua >> sh);
      return 64'(longint'(w));
    end
    sh = int'(o.b[5:0]);
    la = o.a;
    case (o.fs)
      3'd0: r = o.mod ? o.a - o.b : o.a + o.b;
      3'd1: r = o.a << sh;
      3'd2: r = (longint'(o.a) < longint'(o.b)) ? 64'd1 : 64'd0;
      3'd3: r = (o.a < o.b) ? 64'd1 : 64'd0;
      3'd4: r = o.a ^ o.b;
      3'd5: begin
        if (o.mod) r = la >>> sh;
        else r = o.a >> sh;
      end
      3'd6: r = o.a | o.b;
      default: r = o.a & o.b;
    endcase
    return r;
  endfunction

  function automatic out_t predict(op_t o);
    out_t e;
    logic ill;
    ill = o.is_csr & ((o.cr & ~o.crd) | (o.cw & ~o.cwr));
    e.result = ref_result(o);
    e.done = 1; e.rob = o.rob; e.rd = o.rd; e.jump = o.jump;
    e.branch = o.branch; e.pc = o.pc; e.npc = o.npc;
    e.csr_valid = o.is_csr & ~ill;
    e.csr_read = o.cr & ~ill;
    e.csr_write = o.cw & ~ill;
    e.csr_data = o.cdata; e.csr_addr = o.caddr;
    e.exc = ill;
    e.ecause = ill ? 4'd2 : 4'd0;
    return e;
  endfunction

  function automatic op_t sample_bus();
    op_t o;
    o.a = bus.input_a; o.b = bus.input_b; o.half = bus.half;
    o.mod = bus.function_modifier; o.jump = bus.jump_i;
    o.branch = bus.branch_i; o.is_csr = bus.is_csr_i;
    o.fs = bus.function_select; o.pc = bus.pc_i; o.npc = bus.next_pc_i;
    o.caddr = bus.csr_address_i; o.cdata = bus.csr_data_i;
    o.cr = bus.csr_read_i; o.cw = bus.csr_write_i;
    o.crd = bus.csr_readable_i; o.cwr = bus.csr_writeable_i;
    o.rob = bus.rob_index_i; o.rd = bus.rd_addr_i;
    return o;
  endfunction

  // Model of the registered outputs as seen one cycle after each edge.
  always @(posedge clk) begin
    if (rstn || bus.flush) begin
      exp_o   <= zero_out();
      exp_clr <= 1'b1;
    end else if (!bus.stall) begin
      if (bus.valid_i) begin
        exp_o   <= predict(sample_bus());
        exp_clr <= 1'b0;
      end else begin
        exp_o.done <= 1'b0;
      end
    end
  end

  // Compare DUT with model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_ready", 64'(bus.ready_o), 64'(!bus.stall));
      chk("m_done", 64'(bus.done_o), 64'(exp_o.done));
      if (exp_o.done || exp_clr) begin
        chk("m_result", bus.result, exp_o.result);
        chk("m_rob", 64'(bus.rob_index_o), 64'(exp_o.rob));
        chk("m_rd", 64'(bus.rd_addr_o), 64'(exp_o.rd));
        chk("m_jump", 64'(bus.jump_o), 64'(exp_o.jump));
        chk("m_branch", 64'(bus.branch_o), 64'(exp_o.branch));
        chk("m_pc", 64'(bus.pc_o), 64'(exp_o.pc));
        chk("m_npc", 64'(bus.next_pc_o), 64'(exp_o.npc));
        chk("m_csr_valid", 64'(bus.csr_valid_o), 64'(exp_o.csr_valid));
        chk("m_csr_read", 64'(bus.csr_read_o), 64'(exp_o.csr_read));
        chk("m_csr_write", 64'(bus.csr_write_o), 64'(exp_o.csr_write));
        chk("m_csr_data", bus.csr_data_o, exp_o.csr_data);
        chk("m_csr_addr", 64'(bus.csr_address_o), 64'(exp_o.csr_addr));
        chk("m_exc", 64'(bus.exception_valid_o), 64'(exp_o.exc));
        chk("m_ecause", 64'(bus.ecause_o), 64'(exp_o.ecause));
      end
    end
  end

  function automatic op_t base_op(logic [3:0] rob, logic [5:0] rd);
    op_t o;
    o.a = '0; o.b = '0; o.half = 0; o.mod = 0; o.jump = 0; o.branch = 0;
    o.is_csr = 0; o.fs = 3'd0; o.pc = 32'h0000_1000; o.npc = 32'h0000_1004;
    o.caddr = '0; o.cdata = '0; o.cr = 0; o.cw = 0; o.crd = 0; o.cwr = 0;
    o.rob = rob; o.rd = rd;
    return o;
  endfunction

  function automatic logic [63:0] rand_val();
    case ($urandom_range(0, 5))
      0: return 64'(unsigned'($urandom_range(0, 40)));
      1: return '1;
      2: return 64'h8000_0000_0000_0000;
      3: return {32'h0, $urandom};
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  kind;
    o = base_op(4'($urandom), 6'($urandom));
    o.a = rand_val(); o.b = rand_val();
    o.fs = 3'($urandom); o.pc = $urandom; o.npc = o.pc + 32'd4;
    o.caddr = 12'($urandom); o.cdata = {$urandom, $urandom};
    kind = $urandom_range(0, 3);
    if (kind <= 1) begin
      o.half = 1'($urandom); o.mod = 1'($urandom);
    end else if (kind == 2) begin
      o.branch = 1; o.jump = 1'($urandom);
    end else begin
      o.is_csr = 1; o.a = o.cdata;
      o.cr = 1'($urandom); o.cw = 1'($urandom);
      o.crd = ($urandom_range(0, 3) != 0); o.cwr = ($urandom_range(0, 3) != 0);
    end
    return o;
  endfunction

  task automatic put_op(input op_t o);
    bus.input_a = o.a; bus.input_b = o.b; bus.half = o.half;
    bus.function_modifier = o.mod; bus.jump_i = o.jump;
    bus.branch_i = o.branch; bus.is_csr_i = o.is_csr;
    bus.function_select = o.fs; bus.pc_i = o.pc; bus.next_pc_i = o.npc;
    bus.csr_address_i = o.caddr; bus.csr_data_i = o.cdata;
    bus.csr_read_i = o.cr; bus.csr_write_i = o.cw;
    bus.csr_readable_i = o.crd; bus.csr_writeable_i = o.cwr;
    bus.rob_index_i = o.rob; bus.rd_addr_i = o.rd;
    bus.valid_i = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one op, let it be accepted, then stop issuing and wait for negedge.
  task automatic run_one(input op_t o);
    put_op(o);
    step();
    bus.valid_i = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    op_t o;
    n_cmp = 0; n_err = 0; cmp_en = 0;
    rstn = 1'b1;
    bus.stall = 0; bus.flush = 0;
    put_op(base_op(4'd0, 6'd0));
    bus.valid_i = 0;
    step();
    cmp_en = 1;
    repeat (2) step();
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_done", 64'(bus.done_o), 64'd0);
    chk("rst_result", bus.result, 64'd0);
    chk("rst_ready", 64'(bus.ready_o), 64'd1);
    chk("rst_csr_valid", 64'(bus.csr_valid_o), 64'd0);

    step();
    o = base_op(4'd5, 6'd33); o.a = 64'd5; o.b = 64'd7;
    run_one(o);
    chk("add_done", 64'(bus.done_o), 64'd1);
    chk("add_result", bus.result, 64'd12);
    chk("add_rob", 64'(bus.rob_index_o), 64'd5);
    chk("add_rd", 64'(bus.rd_addr_o), 64'd33);
    chk("add_exc", 64'(bus.exception_valid_o), 64'd0);
    @(negedge clk);
    chk("idle_done", 64'(bus.done_o), 64'd0);

    step();
    o = base_op(4'd1, 6'd1); o.half = 1; o.mod = 1; o.a = 0; o.b = 1;
    run_one(o);
    chk("subw_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFF);
    step();
    o = base_op(4'd2, 6'd2); o.fs = 3'd5; o.mod = 1;
    o.a = 64'h8000_0000_0000_0000; o.b = 64'd4;
    run_one(o);
    chk("sra_result", bus.result, 64'hF800_0000_0000_0000);
    step();
    o = base_op(4'd3, 6'd3); o.fs = 3'd2; o.a = '1; o.b = 64'd1;
    run_one(o);
    chk("slt_result", bus.result, 64'd1);
    step();
    o.fs = 3'd3;
    run_one(o);
    chk("sltu_result", bus.result, 64'd0);

    step();
    o = base_op(4'd4, 6'd4); o.branch = 1; o.jump = 1;
    o.a = 64'h1001; o.b = 64'h4; o.pc = 32'h0000_2000; o.npc = 32'h0000_2004;
    run_one(o);
    chk("jalr_result", bus.result, 64'h1004);
    chk("jalr_jump", 64'(bus.jump_o), 64'd1);
    chk("jalr_npc", 64'(bus.next_pc_o), 64'h2004);

    step();
    o = base_op(4'd6, 6'd6); o.is_csr = 1; o.fs = 3'b010;
    o.a = 64'h0F; o.b = 64'hF0; o.cdata = 64'h0F; o.caddr = 12'h300;
    o.cr = 1; o.cw = 1; o.crd = 1; o.cwr = 1;
    run_one(o);
    chk("csrs_result", bus.result, 64'hFF);
    chk("csrs_valid", 64'(bus.csr_valid_o), 64'd1);
    chk("csrs_data", bus.csr_data_o, 64'h0F);
    chk("csrs_exc", 64'(bus.exception_valid_o), 64'd0);
    step();
    o.cwr = 0;
    run_one(o);
    chk("csr_ill_done", 64'(bus.done_o), 64'd1);
    chk("csr_ill_exc", 64'(bus.exception_valid_o), 64'd1);
    chk("csr_ill_cause", 64'(bus.ecause_o), 64'd2);
    chk("csr_ill_valid", 64'(bus.csr_valid_o), 64'd0);
    chk("csr_ill_write", 64'(bus.csr_write_o), 64'd0);

    step();
    o = base_op(4'd9, 6'd9); o.a = 64'd3; o.b = 64'd4;
    put_op(o);
    step();
    o = base_op(4'd10, 6'd10); o.a = 64'd100; o.b = 64'd1;
    put_op(o);
    bus.stall = 1;
    @(negedge clk);
    chk("stall1_done", 64'(bus.done_o), 64'd1);
    chk("stall1_result", bus.result, 64'd7);
    chk("stall1_ready", 64'(bus.ready_o), 64'd0);
    step();
    @(negedge clk);
    chk("stall2_result", bus.result, 64'd7);
    chk("stall2_rob", 64'(bus.rob_index_o), 64'd9);
    step();
    bus.stall = 0; bus.valid_i = 0; bus.flush = 1;
    step();
    bus.flush = 0;
    @(negedge clk);
    chk("flush_done", 64'(bus.done_o), 64'd0);
    chk("flush_result", bus.result, 64'd0);

    step();
    o = base_op(4'd11, 6'd11); o.fs = 3'd4; o.a = 64'hF0F0; o.b = 64'h0FF0;
    o.jump = 1;
    put_op(o);
    step();
    o.a = 64'h1234;
    put_op(o);
    rstn = 1;
    @(negedge clk);
    chk("b2b_result", bus.result, 64'hFF00);
    step();
    rstn = 0; bus.valid_i = 0;
    @(negedge clk);
    chk("midrst_done", 64'(bus.done_o), 64'd0);
    chk("midrst_result", bus.result, 64'd0);
    chk("midrst_rob", 64'(bus.rob_index_o), 64'd0);
    chk("midrst_jump", 64'(bus.jump_o), 64'd0);

    step();
    for (int i = 0; i < 600; i++) begin
      put_op(rand_op());
      bus.valid_i = ($urandom_range(0, 3) != 0);
      bus.stall   = ($urandom_range(0, 9) == 0);
      bus.flush   = ($urandom_range(0, 29) == 0);
      rstn        = ($urandom_range(0, 59) == 0);
      step();
    end
    bus.valid_i = 0; bus.stall = 0; bus.flush = 0; rstn = 0;
    repeat (3) step();
    @(negedge clk);
    cmp_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
